bch_serial_decoder: RTL and testbench



---
 rtl/bch_serial_decoder_if.sv | 25 ++
 rtl/bch_serial_decoder.sv | 245 ++++++++++++++++++++++++
 tb/tb_bch_serial_decoder.sv | 120 ++++++++++++
 3 files changed

// File: rtl/bch_serial_decoder_if.sv
// Handshake bundle for the bit-serial BCH(15,7,2) decoder: serial bit input and decoded message output.
// The slave modport is the decoder side, the master modport the producer/consumer side.
interface bch_serial_decoder_if;
   localparam int unsigned MSG_W = 7;
   localparam int unsigned ERR_W = 2;

   logic             in_valid;
   logic             in_bit;
   logic             in_ready;
   logic             out_valid;
   logic             out_ready;
   logic [MSG_W-1:0] out_data;
   logic [ERR_W-1:0] out_err_count;
   logic             out_uncorrectable;

   modport slave (
      input  in_valid, in_bit, out_ready,
      output in_ready, out_valid, out_data, out_err_count, out_uncorrectable
   );

   modport master (
      output in_valid, in_bit, out_ready,
      input  in_ready, out_valid, out_data, out_err_count, out_uncorrectable
   );
endinterface

// File: rtl/bch_serial_decoder.sv
// Bit-serial BCH(15,7,2) decoder over GF(16) (x^4+x+1): on-the-fly syndromes, locator solve, 15-cycle Chien search.
// Optional macro BCH_EARLY_EXIT_EN: zero-syndrome codewords skip the Chien search.
module bch_serial_decoder #(
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   bch_serial_decoder_if.slave  bus
);
   localparam int unsigned N_BITS = 15;
   localparam int unsigned CNT_W  = 4;
   localparam int unsigned GF_W   = 4;
   localparam int unsigned MSG_W  = 7;
   localparam int unsigned ERR_W  = 2;
   localparam int unsigned LAST   = N_BITS - 1;

   localparam logic [GF_W-1:0] ALPHA1   = 4'h2;
   localparam logic [GF_W-1:0] ALPHA3   = 4'h8;
   localparam logic [GF_W-1:0] ALPHA_M1 = 4'h9;
   localparam logic [GF_W-1:0] ALPHA_M2 = 4'hD;

   localparam logic [1:0] ST_COLLECT = 2'd0;
   localparam logic [1:0] ST_SOLVE   = 2'd1;
   localparam logic [1:0] ST_CHIEN   = 2'd2;
   localparam logic [1:0] ST_OUT     = 2'd3;

   // Shift-add multiply modulo x^4+x+1
   function automatic logic [GF_W-1:0] gf_mul(input logic [GF_W-1:0] a, input logic [GF_W-1:0] b);
      logic [GF_W-1:0] acc;
      logic [GF_W-1:0] x;
      acc = '0;
      x   = a;
      for (int k = 0; k < int'(GF_W); k++) begin
         if (b[k]) acc = acc ^ x;
         x = {x[GF_W-2:0], 1'b0} ^ (x[GF_W-1] ? 4'h3 : 4'h0);
      end
      return acc;
   endfunction

   // a^-1 = a^14 in GF(16)
   function automatic logic [GF_W-1:0] gf_inv(input logic [GF_W-1:0] a);
      logic [GF_W-1:0] a2, a4, a8;
      a2 = gf_mul(a, a);
      a4 = gf_mul(a2, a2);
      a8 = gf_mul(a4, a4);
      return gf_mul(gf_mul(a8, a4), a2);
   endfunction

   logic [1:0]        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [GF_W-1:0]   s1_q, s1_d, s3_q, s3_d;
   logic [GF_W-1:0]   p1_q, p1_d, p3_q, p3_d;
   logic [N_BITS-1:0] buf_q, buf_d;
   logic [MSG_W-1:0]  raw_q, raw_d;
   logic [GF_W-1:0]   t1_q, t1_d, t2_q, t2_d;
   logic [ERR_W-1:0]  exp_q, exp_d;
   logic [ERR_W-1:0]  roots_q, roots_d;
   logic              unc_q, unc_d;
   logic              in_ready_q, in_ready_d;
   logic              out_valid_q, out_valid_d;
   logic [MSG_W-1:0]  out_data_q, out_data_d;
   logic [ERR_W-1:0]  out_err_q, out_err_d;
   logic              out_unc_q, out_unc_d;

   logic [CNT_W-1:0]  pos;
   logic [N_BITS-1:0] in_mask;
   logic [N_BITS-1:0] chien_mask;
   logic [GF_W-1:0]   s1_cube;
   logic [GF_W-1:0]   chien_e;
   logic              chien_bad;

   assign pos        = MSB_FIRST ? (CNT_W'(LAST) - cnt_q) : cnt_q;
   assign in_mask    = N_BITS'(1) << pos;
   assign chien_mask = N_BITS'(1) << cnt_q;
   assign s1_cube    = gf_mul(gf_mul(s1_q, s1_q), s1_q);
   assign chien_e    = 4'h1 ^ t1_q ^ t2_q;

   // Next-state and registered-output logic
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      s1_d        = s1_q;
      s3_d        = s3_q;
      p1_d        = p1_q;
      p3_d        = p3_q;
      buf_d       = buf_q;
      raw_d       = raw_q;
      t1_d        = t1_q;
      t2_d        = t2_q;
      exp_d       = exp_q;
      roots_d     = roots_q;
      unc_d       = unc_q;
      in_ready_d  = in_ready_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_err_d   = out_err_q;
      out_unc_d   = out_unc_q;
      chien_bad   = 1'b0;

      case (state_q)
         ST_COLLECT: begin
            if (bus.in_valid && in_ready_q) begin
               buf_d = (buf_q & ~in_mask) | (bus.in_bit ? in_mask : '0);
               if (MSB_FIRST) begin
                  s1_d = gf_mul(s1_q, ALPHA1) ^ {3'd0, bus.in_bit};
                  s3_d = gf_mul(s3_q, ALPHA3) ^ {3'd0, bus.in_bit};
               end else begin
                  s1_d = s1_q ^ (bus.in_bit ? p1_q : '0);
                  s3_d = s3_q ^ (bus.in_bit ? p3_q : '0);
                  p1_d = gf_mul(p1_q, ALPHA1);
                  p3_d = gf_mul(p3_q, ALPHA3);
               end
               if (cnt_q == CNT_W'(LAST)) begin
                  state_d    = ST_SOLVE;
                  in_ready_d = 1'b0;
                  cnt_d      = '0;
               end else begin
                  cnt_d = cnt_q + 4'd1;
               end
            end
         end

         ST_SOLVE: begin
            cnt_d   = '0;
            roots_d = '0;
            raw_d   = buf_q[N_BITS-1:N_BITS-MSG_W];
            state_d = ST_CHIEN;
            if (s1_q == '0 && s3_q == '0) begin
               t1_d  = '0;
               t2_d  = '0;
               exp_d = 2'd0;
`ifdef BCH_EARLY_EXIT_EN
               state_d     = ST_OUT;
               out_valid_d = 1'b1;
               out_data_d  = buf_q[N_BITS-1:N_BITS-MSG_W];
               out_err_d   = '0;
               out_unc_d   = 1'b0;
`endif
            end else if (s1_q == '0) begin
               unc_d = 1'b1;
               t1_d  = '0;
               t2_d  = '0;
               exp_d = 2'd0;
            end else if (s3_q == s1_cube) begin
               t1_d  = s1_q;
               t2_d  = '0;
               exp_d = 2'd1;
            end else begin
               t1_d  = s1_q;
               t2_d  = gf_mul(s3_q ^ s1_cube, gf_inv(s1_q));
               exp_d = 2'd2;
            end
         end

         ST_CHIEN: begin
            if (chien_e == '0) begin
               buf_d   = buf_q ^ chien_mask;
               roots_d = (roots_q == 2'd3) ? 2'd3 : roots_q + 2'd1;
            end
            t1_d = gf_mul(t1_q, ALPHA_M1);
            t2_d = gf_mul(t2_q, ALPHA_M2);
            if (cnt_q == CNT_W'(LAST)) begin
               // A root count that disagrees with the locator degree means >2 errors
               chien_bad = (roots_d != exp_q) || unc_q;
               if (chien_bad) buf_d[N_BITS-1:N_BITS-MSG_W] = raw_q;
               state_d     = ST_OUT;
               out_valid_d = 1'b1;
               out_data_d  = buf_d[N_BITS-1:N_BITS-MSG_W];
               out_err_d   = chien_bad ? '0 : roots_d;
               out_unc_d   = chien_bad;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end

         ST_OUT: begin
            if (bus.out_ready) begin
               state_d     = ST_COLLECT;
               out_valid_d = 1'b0;
               in_ready_d  = 1'b1;
               cnt_d       = '0;
               s1_d        = '0;
               s3_d        = '0;
               p1_d        = 4'h1;
               p3_d        = 4'h1;
               unc_d       = 1'b0;
               buf_d       = '0;
            end
         end

         default: begin
            state_d = ST_COLLECT;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_COLLECT;
         cnt_q       <= '0;
         s1_q        <= '0;
         s3_q        <= '0;
         p1_q        <= 4'h1;
         p3_q        <= 4'h1;
         buf_q       <= '0;
         raw_q       <= '0;
         t1_q        <= '0;
         t2_q        <= '0;
         exp_q       <= '0;
         roots_q     <= '0;
         unc_q       <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_err_q   <= '0;
         out_unc_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         s1_q        <= s1_d;
         s3_q        <= s3_d;
         p1_q        <= p1_d;
         p3_q        <= p3_d;
         buf_q       <= buf_d;
         raw_q       <= raw_d;
         t1_q        <= t1_d;
         t2_q        <= t2_d;
         exp_q       <= exp_d;
         roots_q     <= roots_d;
         unc_q       <= unc_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_err_q   <= out_err_d;
         out_unc_q   <= out_unc_d;
      end
   end

   assign bus.in_ready          = in_ready_q;
   assign bus.out_valid         = out_valid_q;
   assign bus.out_data          = out_data_q;
   assign bus.out_err_count     = out_err_q;
   assign bus.out_uncorrectable = out_unc_q;

endmodule

// File: tb/tb_bch_serial_decoder.sv
// Directed bench for bch_serial_decoder (MSB first): hand-computed decodes, latency, back-pressure
// hold and mid-Chien asynchronous reset.
module tb_bch_serial_decoder;
   localparam int LAT_FULL = 16;
`ifdef BCH_EARLY_EXIT_EN
   localparam int LAT_ZERO = 1;
`else
   localparam int LAT_ZERO = 16;
`endif

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   checks   = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   bch_serial_decoder_if bus ();

   bch_serial_decoder #(.MSB_FIRST(1'b1)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   // Drive one codeword, bit 14 first; returns #1 after the edge of the last transfer
   task automatic send_word(input logic [14:0] w);
      for (int i = 14; i >= 0; i--) begin
         bus.in_valid = 1'b1;
         bus.in_bit   = w[i];
         @(posedge clk);
         #1;
      end
      bus.in_valid = 1'b0;
      bus.in_bit   = 1'b0;
   endtask

   task automatic wait_out(output int lat);
      lat = 0;
      while (bus.out_valid !== 1'b1 && lat < 40) begin
         @(posedge clk);
         #1;
         lat++;
      end
   endtask

   task automatic run_word(input string tag, input logic [14:0] w, input logic [6:0] ed,
                           input logic [1:0] ee, input logic eu, input int el, input int hold);
      int lat;
      send_word(w);
      chk({tag, "_in_ready_lo"}, 16'(bus.in_ready), 16'd0);
      wait_out(lat);
      chk({tag, "_latency"}, 16'(lat), 16'(el));
      chk({tag, "_data"}, 16'(bus.out_data), 16'(ed));
      chk({tag, "_err_count"}, 16'(bus.out_err_count), 16'(ee));
      chk({tag, "_uncorr"}, 16'(bus.out_uncorrectable), 16'(eu));
      for (int k = 0; k < hold; k++) begin
         bus.in_valid = 1'b1;
         bus.in_bit   = 1'b1;
         @(posedge clk);
         #1;
         chk({tag, "_hold"},
             {4'd0, bus.out_valid, bus.in_ready, bus.out_data, bus.out_err_count, bus.out_uncorrectable},
             {4'd0, 1'b1, 1'b0, ed, ee, eu});
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
      chk({tag, "_released"}, 16'({bus.out_valid, bus.in_ready}), 16'b01);
   endtask

   initial begin
      bus.in_valid  = 1'b0;
      bus.in_bit    = 1'b0;
      bus.out_ready = 1'b0;
      #12;
      chk("reset_outputs",
          {4'd0, bus.out_valid, bus.in_ready, bus.out_data, bus.out_err_count, bus.out_uncorrectable},
          {4'd0, 1'b0, 1'b1, 7'h00, 2'd0, 1'b0});
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      run_word("zero_word",   15'h0000, 7'h00, 2'd0, 1'b0, LAT_ZERO, 0);
      run_word("single_b9",   15'h03D1, 7'h01, 2'd1, 1'b0, LAT_FULL, 0);
      run_word("double_b14_2",15'h41D5, 7'h01, 2'd2, 1'b0, LAT_FULL, 0);
      run_word("triple_uncor",15'h0013, 7'h00, 2'd0, 1'b1, LAT_FULL, 5);
      run_word("parity_b0",   15'h01D0, 7'h01, 2'd1, 1'b0, LAT_FULL, 0);

      // Reset during Chien step i=7
      send_word(15'h01D1);
      repeat (8) @(posedge clk);
      #2;
      chk("pre_reset_busy", 16'({bus.in_ready, bus.out_valid}), 16'b00);
      rst_n = 1'b0;
      #1;
      chk("mid_chien_reset",
          {4'd0, bus.out_valid, bus.in_ready, bus.out_data, bus.out_err_count, bus.out_uncorrectable},
          {4'd0, 1'b0, 1'b1, 7'h00, 2'd0, 1'b0});
      #3;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      run_word("after_reset", 15'h01D1, 7'h01, 2'd0, 1'b0, LAT_FULL, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
